// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver with start framing,
// a one-word valid/ready holding register and a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       start,
  input  logic                       serial_in,
  input  logic                       out_ready,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  seed_word;
  logic [WIDTH-1:0]  shifted_word;
  logic              word_done;
  logic              accept;
  logic              drop;
  logic              valid_d;
  logic              overrun_d;

  // The first bit is seeded at the end that the shift will carry to its final slot.
  assign seed_word    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, serial_in}
                                  : {serial_in, {(WIDTH-1){1'b0}}};
  assign shifted_word = MSB_FIRST ? {shreg_q[WIDTH-2:0], serial_in}
                                  : {serial_in, shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
    word_done = 1'b0;
    if (enable) begin
      if (start) begin
        state_d = SHIFT;
        shreg_d = seed_word;
        count_d = CW'(1);
      end else if (state_q == SHIFT) begin
        shreg_d = shifted_word;
        if (count_q == LAST) begin
          word_done = 1'b1;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  // A completing word is taken only if the holding register is empty or draining now.
  always_comb begin
    accept    = word_done && (!out_valid || out_ready);
    drop      = word_done && out_valid && !out_ready;
    valid_d   = accept || (out_valid && !out_ready);
    overrun_d = drop || (overrun && !clear_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        parallel_out <= shifted_word;
      end
      out_valid <= valid_d;
      overrun   <= overrun_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign bit_count = count_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer: vector table,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       serial_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] parallel_out, parallel_out_lsb;
  logic       out_valid, out_valid_lsb;
  logic       busy, busy_lsb;
  logic [3:0] bit_count, bit_count_lsb;
  logic       overrun, overrun_lsb;

  int total = 0;
  int bad = 0;
  int xfers = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .clear_err(clear_err), .parallel_out(parallel_out),
    .out_valid(out_valid), .busy(busy), .bit_count(bit_count), .overrun(overrun));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .serial_in(serial_in),
    .out_ready(out_ready), .clear_err(clear_err), .parallel_out(parallel_out_lsb),
    .out_valid(out_valid_lsb), .busy(busy_lsb), .bit_count(bit_count_lsb), .overrun(overrun_lsb));

  // Reference: the frame is a queue of received bits; words are assembled arithmetically.
  bit         m_bits[$];
  logic       m_v, m_ov;
  logic [7:0] m_w, m_wl;

  task automatic model_clear();
    m_bits.delete();
    m_v = 1'b0; m_ov = 1'b0; m_w = 8'h00; m_wl = 8'h00;
  endtask

  task automatic model_update();
    bit done = 1'b0;
    bit drop;
    logic [7:0] nw = 8'h00;
    logic [7:0] nwl = 8'h00;
    if (enable) begin
      if (start) begin
        m_bits.delete();
        m_bits.push_back(serial_in);
      end else if (m_bits.size() != 0) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == 8) begin
          done = 1'b1;
          for (int i = 0; i < 8; i++) begin
            nw  = nw  | (8'(m_bits[i]) << (7 - i));
            nwl = nwl | (8'(m_bits[i]) << i);
          end
          m_bits.delete();
        end
      end
    end
    drop = done && m_v && !out_ready;
    if (done && !drop) begin
      m_w = nw; m_wl = nwl; m_v = 1'b1;
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
    m_ov = drop || (m_ov && !clear_err);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("rnd_valid", 32'(out_valid), 32'(m_v));
    chk("rnd_word", 32'(parallel_out), 32'(m_w));
    chk("rnd_busy", 32'(busy), 32'(m_bits.size() != 0));
    chk("rnd_count", 32'(bit_count), 32'(m_bits.size()));
    chk("rnd_overrun", 32'(overrun), 32'(m_ov));
    chk("rnd_word_lsb", 32'(parallel_out_lsb), 32'(m_wl));
  endtask

  task automatic step();
    if (out_valid && out_ready) xfers++;
    @(posedge clk);
    if (reset) model_update();
    #1;
    if (model_on) check_model();
  endtask

  task automatic send_bit(input logic en, input logic st, input logic d,
                          input logic rdy, input logic clr);
    enable = en; start = st; serial_in = d; out_ready = rdy; clear_err = clr;
    step();
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic clr_last);
    for (int i = 0; i < 8; i++)
      send_bit(1'b1, i == 0, w[7-i], rdy, (i == 7) ? clr_last : 1'b0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    enable = 1'b0; start = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic en, st, d, rdy, clr;
    logic v; logic [7:0] w; logic b; int cnt; logic ov;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(logic en, logic st, logic d, logic rdy, logic clr,
                              logic v, logic [7:0] w, logic b, int cnt, logic ov);
    vec_t r;
    r.en = en; r.st = st; r.d = d; r.rdy = rdy; r.clr = clr;
    r.v = v; r.w = w; r.b = b; r.cnt = cnt; r.ov = ov;
    return r;
  endfunction

  initial begin
    vt[0] = mk(1, 1, 1, 1, 0,  0, 8'h00, 1, 1, 0);
    vt[1] = mk(1, 0, 0, 1, 0,  0, 8'h00, 1, 2, 0);
    vt[2] = mk(1, 0, 0, 1, 0,  0, 8'h00, 1, 3, 0);
    vt[3] = mk(1, 0, 1, 1, 0,  0, 8'h00, 1, 4, 0);
    vt[4] = mk(1, 0, 0, 1, 0,  0, 8'h00, 1, 5, 0);
    vt[5] = mk(1, 0, 1, 1, 0,  0, 8'h00, 1, 6, 0);
    vt[6] = mk(1, 0, 1, 1, 0,  0, 8'h00, 1, 7, 0);
    vt[7] = mk(1, 0, 0, 1, 0,  1, 8'h96, 0, 0, 0);
    vt[8] = mk(0, 0, 0, 1, 0,  0, 8'h96, 0, 0, 0);

    do_reset();
    #1;
    chk("reset_word", 32'(parallel_out), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_count", 32'(bit_count), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);

    // MSB-first word 0x96 through the vector table
    foreach (vt[i]) begin
      send_bit(vt[i].en, vt[i].st, vt[i].d, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_word", i), 32'(parallel_out), 32'(vt[i].w));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("vec%0d_count", i), 32'(bit_count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vt[i].ov));
      if (i == 7) chk("vec_lsb_word", 32'(parallel_out_lsb), 32'h69);
    end

    // Asynchronous reset mid-frame
    send_bit(1, 1, 1, 0, 0);
    send_bit(1, 0, 0, 0, 0);
    send_bit(1, 0, 1, 0, 0);
    send_bit(1, 0, 1, 0, 0);
    chk("midframe_count", 32'(bit_count), 32'd4);
    #3 reset = 1'b0;
    #1;
    chk("async_word", 32'(parallel_out), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_count", 32'(bit_count), 32'h0);
    chk("async_overrun", 32'(overrun), 32'h0);
    model_clear();
    #2 reset = 1'b1;
    #1;

    // Stall: 0x62 with enable low for 3 cycles after bit 4
    send_bit(1, 1, 0, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      send_bit(0, 0, 1, 1, 0);
      chk("stall_count", 32'(bit_count), 32'd4);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    send_bit(1, 0, 0, 1, 0);
    send_bit(1, 0, 0, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 0, 0, 1, 0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_word", 32'(parallel_out), 32'h62);
    send_bit(0, 0, 0, 1, 0);
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Back-to-back frames with no gap
    xfers = 0;
    send_word(8'h96, 1, 0);
    chk("b2b_first_word", 32'(parallel_out), 32'h96);
    send_word(8'h62, 1, 0);
    chk("b2b_second_word", 32'(parallel_out), 32'h62);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    send_bit(0, 0, 0, 1, 0);
    chk("b2b_xfers", 32'(xfers), 32'd2);
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // Back-pressure, overrun, clear and set-wins-over-clear
    send_word(8'h96, 0, 0);
    send_word(8'h00, 0, 0);
    chk("bp_word", 32'(parallel_out), 32'h96);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    send_bit(0, 0, 0, 0, 1);
    chk("bp_cleared", 32'(overrun), 32'd0);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    send_word(8'hFF, 0, 1);
    chk("bp_set_wins", 32'(overrun), 32'd1);
    chk("bp_word_kept", 32'(parallel_out), 32'h96);
    send_bit(0, 0, 0, 1, 1);
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_overrun", 32'(overrun), 32'd0);

    // Resync: start again at bit 5, then 0xA5
    send_bit(1, 1, 1, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 0, 1, 1, 0);
    send_bit(1, 1, 1, 1, 0);
    chk("resync_count", 32'(bit_count), 32'd1);
    chk("resync_no_valid", 32'(out_valid), 32'd0);
    begin
      logic [7:0] a5 = 8'hA5;
      for (int i = 1; i < 8; i++) begin
        send_bit(1, 0, a5[7-i], 1, 0);
        if (i < 7) chk("resync_partial_hidden", 32'(out_valid), 32'd0);
      end
    end
    chk("resync_word", 32'(parallel_out), 32'hA5);
    chk("resync_valid", 32'(out_valid), 32'd1);
    chk("resync_lsb_word", 32'(parallel_out_lsb), 32'hA5);

    // Randomized traffic against the model
    do_reset();
    #1;
    model_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      send_bit($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, 1'($urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
